// File: rtl/fa32_accumulator.sv
// Multi-operand accumulator: sums a valid/ready burst of 32-bit operands through one
// ripple full_adder_32bit and reports the sum plus a saturating count of carry-outs.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module full_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] c;

  assign c[0] = cin;
  assign cout = c[32];

  for (genvar i = 0; i < 32; i++) begin : g_bit
    fa_cell u_cell (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
  end
endmodule

module fa32_accumulator #(
  parameter int CNT_W   = 8,
  parameter int CARRY_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   op_count,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_sum,
  output logic [CARRY_W-1:0] out_carry_cnt,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        acc_q;
  logic [CNT_W-1:0]   rem_q;
  logic [CARRY_W-1:0] carry_q;
  logic [31:0]        fa_sum;
  logic               fa_cout;
  logic               xfer;

  full_adder_32bit u_fa (.a(acc_q), .b(in_data), .cin(1'b0), .sum(fa_sum), .cout(fa_cout));

  assign xfer = in_valid && (state_q == ACCUM);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (op_count == '0) ? DONE : ACCUM;
      ACCUM:   if (xfer && rem_q == CNT_W'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      carry_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        acc_q   <= '0;
        carry_q <= '0;
        rem_q   <= op_count;
      end else if (xfer) begin
        acc_q <= fa_sum;
        rem_q <= rem_q - CNT_W'(1);
        // counter sticks at all-ones once saturated
        if (fa_cout && carry_q != '1) carry_q <= carry_q + CARRY_W'(1);
      end
    end
  end

  assign in_ready      = (state_q == ACCUM);
  assign out_valid     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign out_sum       = acc_q;
  assign out_carry_cnt = carry_q;
endmodule

// File: tb/tb_fa32_accumulator.sv
// Directed bench for fa32_accumulator: a default instance and a CARRY_W=2 instance share
// stimulus; a transaction-level model is compared every cycle, plus literal expectations.
module tb_fa32_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  op_count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, busy_a;
  logic [31:0] out_sum_a;
  logic [7:0]  carry_a;
  logic        in_ready_b, out_valid_b, busy_b;
  logic [31:0] out_sum_b;
  logic [1:0]  carry_b;

  fa32_accumulator dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .op_count(op_count),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a),
    .out_carry_cnt(carry_a), .busy(busy_a)
  );

  fa32_accumulator #(.CNT_W(8), .CARRY_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .op_count(op_count),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
    .out_carry_cnt(carry_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // model: phase 0 waiting for start, 1 taking operands, 2 holding a result
  int          m_phase, m_rem, m_c8, m_c2;
  logic [31:0] m_sum;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic model_reset();
    m_phase = 0; m_rem = 0; m_c8 = 0; m_c2 = 0; m_sum = '0;
  endtask

  task automatic model_step();
    logic [32:0] s;
    case (m_phase)
      0: if (start) begin
           m_sum = '0; m_c8 = 0; m_c2 = 0; m_rem = int'(op_count);
           m_phase = (op_count == 0) ? 2 : 1;
         end
      1: if (in_valid) begin
           s = {1'b0, m_sum} + {1'b0, in_data};
           m_sum = s[31:0];
           if (s[32]) begin
             if (m_c8 < 255) m_c8++;
             if (m_c2 < 3)   m_c2++;
           end
           m_rem--;
           if (m_rem == 0) m_phase = 2;
         end
      default: if (out_ready) m_phase = 0;
    endcase
  endtask

  task automatic compare();
    chk("in_ready_a",  in_ready_a,  m_phase == 1);
    chk("out_valid_a", out_valid_a, m_phase == 2);
    chk("busy_a",      busy_a,      m_phase != 0);
    chk("in_ready_b",  in_ready_b,  m_phase == 1);
    chk("out_valid_b", out_valid_b, m_phase == 2);
    chk("busy_b",      busy_b,      m_phase != 0);
    if (m_phase == 2) begin
      chk("out_sum_a", out_sum_a, m_sum);
      chk("carry_a",   carry_a,   m_c8);
      chk("out_sum_b", out_sum_b, m_sum);
      chk("carry_b",   carry_b,   m_c2);
    end
  endtask

  task automatic tick();
    if (rst_n) model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"},  in_ready_a,  0);
    chk({tag, "_out_valid"}, out_valid_a, 0);
    chk({tag, "_busy"},      busy_a,      0);
    chk({tag, "_sum"},       out_sum_a,   0);
    chk({tag, "_carry"},     carry_a,     0);
    chk({tag, "_sum_b"},     out_sum_b,   0);
    chk({tag, "_carry_b"},   carry_b,     0);
  endtask

  // lat counts cycles from the start cycle until out_valid is seen
  task automatic burst(input int n, input logic [31:0] ops [8], input bit gaps, output int lat);
    int i = 0;
    bit ph = 1'b0;
    start = 1'b1; op_count = 8'(n);
    tick();
    start = gaps;  // a start held during ACCUM must be ignored
    op_count = 8'd0;
    lat = 1;
    while (!out_valid_a && lat < 64) begin
      if (i < n && !(gaps && ph)) begin
        in_valid = 1'b1; in_data = ops[i];
      end else begin
        in_valid = 1'b0; in_data = $urandom;
      end
      ph = ~ph;
      tick();
      lat++;
      if (in_valid) i++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk("burst_completed", out_valid_a, 1);
  endtask

  task automatic drain(input int hold);
    out_ready = 1'b0;
    repeat (hold) begin
      tick();
      chk("hold_busy", busy_a, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drained", out_valid_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ops [8];
    int lat;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: three operands back-to-back
    ops = '{32'd5465, 32'd52, 32'd5895, 0, 0, 0, 0, 0};
    burst(3, ops, 1'b0, lat);
    chk("t1_latency", lat, 4);
    chk("t1_sum", out_sum_a, 11412);
    chk("t1_carry", carry_a, 0);
    drain(0);

    // 2: wrap produces one carry
    ops = '{32'hFFFF_FFFF, 32'h2, 0, 0, 0, 0, 0, 0};
    burst(2, ops, 1'b0, lat);
    chk("t2_latency", lat, 3);
    chk("t2_sum", out_sum_a, 1);
    chk("t2_carry", carry_a, 1);
    chk("t2_carry_b", carry_b, 1);
    drain(0);

    // 3: in_valid toggling, start held high mid-burst
    ops = '{32'd245, 32'd52, 32'd5, 32'd2, 0, 0, 0, 0};
    burst(4, ops, 1'b1, lat);
    chk("t3_latency", lat, 8);
    chk("t3_sum", out_sum_a, 304);
    drain(0);

    // 4: empty burst, consumer stalls
    burst(0, ops, 1'b0, lat);
    chk("t4_latency", lat, 1);
    chk("t4_sum", out_sum_a, 0);
    chk("t4_carry", carry_a, 0);
    drain(5);
    chk("t4_after_sum_kept", out_sum_a, 0);

    // 5: reset aborts a burst after one operand
    start = 1'b1; op_count = 8'd3;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 32'd100;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_zero("abort");
    tick();
    chk("abort_idle", busy_a, 0);
    rst_n = 1'b1;
    ops = '{32'd8, 32'd5254, 0, 0, 0, 0, 0, 0};
    burst(2, ops, 1'b0, lat);
    chk("t5_sum", out_sum_a, 5262);
    chk("t5_carry", carry_a, 0);
    drain(0);

    // 6: five all-ones operands saturate the narrow counter
    ops = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0};
    burst(5, ops, 1'b0, lat);
    chk("t6_latency", lat, 6);
    chk("t6_sum", out_sum_b, 32'hFFFF_FFFB);
    chk("t6_carry_b", carry_b, 3);
    chk("t6_carry_a", carry_a, 4);
    drain(2);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
